fetch_stage: RTL and testbench

Instruction-fetch front end for the pipelined RV32I core. Owns the architectural PC, drives the combinational instruction-memory read port, and registers the fetched word into the IF/ID pipeline register feeding decode. Honours stall requests from the hazard unit and redirect/flush requests from the execute stage. Detects misaligned redirect targets.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage_if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: reset/bubble
// constants, the fetch FSM state encoding and a small alignment helper.
package fetch_stage_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  // addi x0,x0,0 -- the canonical bubble placed in IF/ID on reset and flush
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  // RV32I without compressed instructions needs word-aligned targets
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory port, control inputs and IF/ID outputs.
//
// Control semantics: stall and redirect are level requests sampled on every
// rising clk edge while the stage is running. redirect has priority over
// stall; redirect_pc is only looked at when redirect=1. There is no ready
// back-pressure: a request is accepted on the edge where it is seen.
// imem_rdata must be a combinational function of imem_addr in the same cycle.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  import fetch_stage_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            fetch_err;
  logic [31:0]     fetch_count;
  fetch_state_t    state;

  // The fetch stage itself
  modport master (
    output imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid,
           fetch_err, fetch_count, state,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  // Memory, hazard unit, execute stage and decode around it
  modport slave (
    input  imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid,
           fetch_err, fetch_count, state,
    output imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats hold beats load. A flush turns the
// slot into a NOP bubble but leaves the PC fields alone so later stages can
// still see where the bubble sits.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [31:0]     in_instr,
  input  logic            in_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic            valid
);

  // Pipeline slot: reset to bubble, flush to bubble, else hold or load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      valid    <= 1'b0;
    end else if (!hold) begin
      pc       <= in_pc;
      pc_plus4 <= in_pc_plus4;
      instr    <= in_instr;
      valid    <= in_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the combinational
// instruction-memory address and fills the IF/ID register. One BOOT cycle
// after reset, then RUN until a misaligned redirect parks it in HALT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input logic            clk,
  input logic            rst,
  fetch_stage_if.master  bus
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic            fetch_err_q;
  logic [31:0]     fetch_count_q;

  logic            in_run;
  logic            do_fetch;
  logic            flush;
  logic [XLEN-1:0] pc_plus4;

  assign in_run   = (state_q == FETCH_RUN);
  // A fetch happens only on a plain RUN cycle; redirect or stall suppress it
  assign do_fetch = in_run && !bus.redirect && !bus.stall;
  // Any accepted redirect (good or bad) kills the slot; HALT keeps it dead
  assign flush    = (in_run && bus.redirect) || (state_q == FETCH_HALT);
  assign pc_plus4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  // Fetch FSM with PC, sticky error flag and fetch counter as registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_BOOT;
      pc_q          <= RESET_PC;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        FETCH_BOOT: state_q <= FETCH_RUN;
        FETCH_RUN: begin
          if (bus.redirect) begin
            if (is_misaligned(bus.redirect_pc[1:0])) begin
              state_q     <= FETCH_HALT;
              fetch_err_q <= 1'b1;
            end else begin
              pc_q <= bus.redirect_pc;
            end
          end else if (!bus.stall) begin
            pc_q          <= pc_plus4;
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        FETCH_HALT: state_q <= FETCH_HALT;
        default:    state_q <= FETCH_HALT;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .hold        (!do_fetch),
    .flush       (flush),
    .in_pc       (pc_q),
    .in_pc_plus4 (pc_plus4),
    .in_instr    (bus.imem_rdata),
    .in_valid    (1'b1),
    .pc          (bus.if_id_pc),
    .pc_plus4    (bus.if_id_pc_plus4),
    .instr       (bus.if_id_instr),
    .valid       (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against a behavioural model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and instruction memory: each word is its address xor a fixed mask
  always #5 clk = ~clk;
  assign bus.imem_rdata = bus.imem_addr ^ MASK;

  // Behavioural model of what the stage must present
  logic [31:0] m_pc, m_ipc, m_plus4, m_instr, m_cnt;
  bit          m_valid, m_err, m_booting, m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_plus4 = 32'h0; m_instr = NOP; m_cnt = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_booting = 1'b1; m_halted = 1'b0;
  endfunction

  // Apply the fetch rules for the coming edge, using inputs as they stand now
  function automatic void model_step();
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_halted) begin
      if (bus.redirect) begin
        m_valid = 1'b0;
        m_instr = NOP;
        if (bus.redirect_pc % 4 != 0) begin
          m_halted = 1'b1;
          m_err    = 1'b1;
        end else begin
          m_pc = bus.redirect_pc;
        end
      end else if (!bus.stall) begin
        m_ipc   = m_pc;
        m_plus4 = m_pc + 32'd4;
        m_instr = m_pc ^ MASK;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_cnt   = m_cnt + 32'd1;
      end
    end
  endfunction

  always @(negedge clk) if (rst === 1'b1) model_step();

  // Compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("imem_addr", bus.imem_addr, m_pc);
      check("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_valid});
      check("if_id_instr", bus.if_id_instr, m_instr);
      check("if_id_pc", bus.if_id_pc, m_ipc);
      check("if_id_pc_plus4", bus.if_id_pc_plus4, m_plus4);
      check("fetch_err", {31'b0, bus.fetch_err}, {31'b0, m_err});
      check("fetch_count", bus.fetch_count, m_cnt);
      check("state", {30'b0, bus.state},
            {30'b0, m_halted ? FETCH_HALT : (m_booting ? FETCH_BOOT : FETCH_RUN)});
    end
  end

  // Advance one edge; inputs may be changed afterwards
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    model_reset();
    cyc();
    rst = 1'b1;
  endtask

  // Assert reset between edges and confirm outputs clear before the next edge
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    model_reset();
    #2;
    check({tag, "_valid"}, {31'b0, bus.if_id_valid}, 32'd0);
    check({tag, "_instr"}, bus.if_id_instr, NOP);
    check({tag, "_addr"}, bus.imem_addr, 32'h0);
    check({tag, "_count"}, bus.fetch_count, 32'h0);
    check({tag, "_pc"}, bus.if_id_pc, 32'h0);
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    model_reset();
    chk_en = 1'b1;
    cyc();
    check("rst_valid", {31'b0, bus.if_id_valid}, 32'd0);
    check("rst_instr", bus.if_id_instr, NOP);
    check("rst_count", bus.fetch_count, 32'd0);
    rst = 1'b1;

    // BOOT cycle, then three sequential fetches
    cyc();
    check("boot_valid", {31'b0, bus.if_id_valid}, 32'd0);
    cyc();
    check("f0_pc", bus.if_id_pc, 32'h0);
    check("f0_instr", bus.if_id_instr, 32'hA5A5_0000);
    cyc();
    check("f1_pc", bus.if_id_pc, 32'h4);
    cyc();
    check("f2_pc", bus.if_id_pc, 32'h8);
    check("f2_instr", bus.if_id_instr, 32'hA5A5_0008);
    check("f2_count", bus.fetch_count, 32'd3);

    // Two stalled cycles freeze everything
    bus.stall = 1'b1;
    cyc();
    cyc();
    check("stall_pc", bus.if_id_pc, 32'h8);
    check("stall_addr", bus.imem_addr, 32'hC);
    check("stall_count", bus.fetch_count, 32'd3);
    bus.stall = 1'b0;
    cyc();
    check("resume_pc", bus.if_id_pc, 32'hC);

    // Redirect wins over stall
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    cyc();
    check("redir_valid", {31'b0, bus.if_id_valid}, 32'd0);
    check("redir_instr", bus.if_id_instr, NOP);
    check("redir_addr", bus.imem_addr, 32'h100);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    cyc();
    check("tgt_pc", bus.if_id_pc, 32'h100);
    check("tgt_plus4", bus.if_id_pc_plus4, 32'h104);

    // PC wraps at the top of the address space without error
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    check("top_pc", bus.if_id_pc, 32'hFFFF_FFFC);
    check("top_plus4", bus.if_id_pc_plus4, 32'h0);
    cyc();
    check("wrap_pc", bus.if_id_pc, 32'h0);
    check("wrap_err", {31'b0, bus.fetch_err}, 32'd0);

    // Misaligned target halts the stage until reset
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0102;
    cyc();
    bus.redirect = 1'b0;
    check("mis_err", {31'b0, bus.fetch_err}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.stall = 1'($urandom_range(0, 1));
      bus.redirect = 1'($urandom_range(0, 1));
      bus.redirect_pc = {$urandom_range(0, 255), 2'b00};
      cyc();
      check("halt_valid", {31'b0, bus.if_id_valid}, 32'd0);
    end
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    reset_pulse();
    check("clr_err", {31'b0, bus.fetch_err}, 32'd0);
    check("clr_addr", bus.imem_addr, 32'h0);

    // Asynchronous reset in the middle of a run
    repeat (5) cyc();
    async_reset("arst");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 15))
        0:       bus.redirect_pc = {$urandom_range(0, 1023), 2'b00} | 32'(1 + $urandom_range(0, 2));
        1, 2:    bus.redirect_pc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
        default: bus.redirect_pc = {$urandom_range(0, 1023), 2'b00};
      endcase
      if (m_halted && $urandom_range(0, 5) == 0) reset_pulse();
      else if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        async_reset("rnd_arst");
      end else cyc();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
